// File: rtl/uart8_tx_feeder_pkg.sv
// Shared definitions for the UART transmit feeder: byte width and the
// feeder FSM encodings.
package uart8_tx_feeder_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        FEED_DRAIN     = 2'd0,
        FEED_IDLE      = 2'd1,
        FEED_WAIT_BUSY = 2'd2,
        FEED_ACTIVE    = 2'd3
    } feed_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock byte FIFO with a registered occupancy counter and a
// combinational head output; shared by the UART transmit and receive paths.
module uart_sync_fifo
    import uart8_tx_feeder_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [BYTE_W-1:0] din,
    output logic [BYTE_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level
);

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (level == (ADDR_W+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally; level disambiguates full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart8_tx_feeder.sv
// Byte FIFO plus handshake FSM that keeps the 8-bit UART transmitter fed with
// back-to-back frames in both turbo and non-turbo stop-bit modes.
module uart8_tx_feeder
    import uart8_tx_feeder_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [BYTE_W-1:0] wr_data,
    input  logic              tx_busy,
    input  logic              tx_done,
    output logic              tx_start,
    output logic [BYTE_W-1:0] tx_data,
    output logic [ADDR_W:0]   level,
    output logic              idle
);

    feed_state_t state;
    logic        done_q;
    logic        start_q;
    logic        done_rise;
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;

    assign done_rise = tx_done && !done_q;
    assign wr_ready  = !full;
    assign push      = wr_valid && wr_ready;
    assign idle      = empty && (state == FEED_IDLE);

    uart_sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (wr_data),
        .dout  (tx_data),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    // At the stop-bit done edge, start_q tells whether the transmitter latched
    // the head byte on the previous edge: if so, hold start high and pop; if
    // not, start must stay low or the transmitter resends its stale byte.
    always_comb begin
        tx_start = 1'b0;
        pop      = 1'b0;
        case (state)
            FEED_IDLE: begin
                tx_start = !empty;
                pop      = !empty && !tx_busy;
            end
            FEED_ACTIVE: begin
                if (done_rise) begin
                    tx_start = start_q;
                    pop      = start_q;
                end else begin
                    tx_start = !empty;
                end
            end
            default: begin
                tx_start = 1'b0;
                pop      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= FEED_DRAIN;
            done_q  <= 1'b0;
            start_q <= 1'b0;
        end else begin
            done_q  <= tx_done;
            start_q <= tx_start;
            case (state)
                FEED_DRAIN: begin
                    if (!tx_busy && !tx_done) begin
                        state <= FEED_IDLE;
                    end
                end
                FEED_IDLE: begin
                    if (pop) begin
                        state <= FEED_WAIT_BUSY;
                    end
                end
                FEED_WAIT_BUSY: begin
                    if (tx_busy) begin
                        state <= FEED_ACTIVE;
                    end
                end
                FEED_ACTIVE: begin
                    if (done_rise && !start_q) begin
                        state <= FEED_DRAIN;
                    end
                end
                default: state <= FEED_DRAIN;
            endcase
        end
    end

endmodule

// File: tb/tb_uart8_tx_feeder.sv
// Bench for uart8_tx_feeder: a cycle-level transmitter model drives busy/done,
// a line receiver rebuilds the bytes, and each task checks its scenario.
module tb_uart8_tx_feeder;

    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);
    localparam int T_IDLE = 0, T_START = 1, T_DATA = 2, T_STOP1 = 3, T_STOP = 4, T_RESET = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_valid = 1'b0;
    logic [7:0]    wr_data = 8'h00;
    logic          wr_ready, tx_busy, tx_done, tx_start, idle, tx_line;
    logic [7:0]    tx_data;
    logic [AW:0]   level;

    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    int            start_cnt = 0;
    bit            turbo = 1'b1;
    bit            stall = 1'b0;
    bit            stall_prev = 1'b0;

    // transmitter model state
    int            ts = T_IDLE;
    logic [2:0]    bidx = 3'd0;
    logic [7:0]    shreg = 8'h00;
    bit            chained = 1'b0;

    // line receiver state
    bit            rx_on = 1'b0;
    logic [3:0]    rx_cnt = 4'd0;
    logic [7:0]    rx_sh = 8'h00;
    logic [8:0]    rx_q[$];
    int            rx_t[$];

    always #5 clk = ~clk;

    uart8_tx_feeder #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_data  (wr_data),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .level    (level),
        .idle     (idle)
    );

    // Transmitter: latches txIn on the edge entering its final stop cycle when
    // start is high, and in that cycle chains on start or falls to RESET.
    assign tx_busy = (ts == T_DATA) || (ts == T_STOP1) || (ts == T_STOP) || (ts == T_START && chained);
    assign tx_done = (ts == T_STOP) || (ts == T_RESET);
    assign tx_line = (ts == T_START) ? 1'b0 : (ts == T_DATA) ? shreg[bidx] : 1'b1;

    always @(posedge clk) begin
        if (!stall) begin
            case (ts)
                T_IDLE: if (tx_start === 1'b1) begin shreg <= tx_data; chained <= 1'b0; ts <= T_START; end
                T_START: begin bidx <= 3'd0; ts <= T_DATA; end
                T_DATA: begin
                    if (bidx == 3'd7) begin
                        if (turbo) begin
                            if (tx_start === 1'b1) shreg <= tx_data;
                            ts <= T_STOP;
                        end else begin
                            ts <= T_STOP1;
                        end
                    end else begin
                        bidx <= bidx + 3'd1;
                    end
                end
                T_STOP1: begin
                    if (tx_start === 1'b1) shreg <= tx_data;
                    ts <= T_STOP;
                end
                T_STOP: begin
                    if (tx_start === 1'b1) begin chained <= 1'b1; ts <= T_START; end
                    else ts <= T_RESET;
                end
                default: ts <= T_IDLE;
            endcase
        end
    end

    // Receiver: one line sample per baud cycle; frozen (stalled) cycles skipped.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        stall_prev <= stall;
        if (!stall_prev) begin
            if (!rx_on) begin
                if (tx_line == 1'b0) begin
                    rx_on <= 1'b1;
                    rx_cnt <= 4'd0;
                    rx_t.push_back(cyc);
                end
            end else if (rx_cnt < 4'd8) begin
                rx_sh[rx_cnt[2:0]] <= tx_line;
                rx_cnt <= rx_cnt + 4'd1;
            end else begin
                rx_q.push_back({~tx_line, rx_sh});
                rx_on <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (tx_start === 1'b1) start_cnt <= start_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        while (wr_ready !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
        wr_valid = 1'b1;
        wr_data  = b;
        @(posedge clk);
        #1 wr_valid = 1'b0;
    endtask

    task automatic wait_frames(input int target, input int budget, output bit ok);
        int n = 0;
        while (rx_q.size() < target && n < budget) begin @(negedge clk); n++; end
        ok = (rx_q.size() >= target);
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        int n = 0;
        @(negedge clk);
        while (!(idle === 1'b1 && ts == T_IDLE) && n < budget) begin @(negedge clk); n++; end
        ok = (idle === 1'b1 && ts == T_IDLE);
    endtask

    task automatic test_reset();
        bit ok;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (level !== '0) begin bad++; $display("FAIL reset_level got=%0d want=0", level); end
        total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL reset_wr_ready got=%b want=1", wr_ready); end
        total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL reset_tx_start got=%b want=0", tx_start); end
        total++; if (idle !== 1'b0) begin bad++; $display("FAIL reset_idle got=%b want=0", idle); end
        rst_n = 1'b1;
        wait_idle(50, ok);
        total++; if (!ok) begin bad++; $display("FAIL reset_to_idle got=%b want=1", idle); end
    endtask

    task automatic test_single();
        bit ok;
        int base = rx_q.size();
        int s0 = start_cnt;
        send(8'hA5);
        @(negedge clk);
        total++; if (level !== 1) begin bad++; $display("FAIL single_level1 got=%0d want=1", level); end
        total++; if (tx_start !== 1'b1) begin bad++; $display("FAIL single_start got=%b want=1", tx_start); end
        @(negedge clk);
        total++; if (level !== 0) begin bad++; $display("FAIL single_level0 got=%0d want=0", level); end
        wait_frames(base + 1, 300, ok);
        total++; if (!ok || rx_q[base] !== 9'h0A5) begin bad++; $display("FAIL single_frame got=%h want=0a5", rx_q[base]); end
        wait_idle(100, ok);
        total++; if (!ok) begin bad++; $display("FAIL single_idle got=%b want=1", idle); end
        total++; if (start_cnt - s0 != 1) begin bad++; $display("FAIL single_start_cycles got=%0d want=1", start_cnt - s0); end
    endtask

    task automatic test_burst(input bit mode);
        bit ok;
        int base, drops, n;
        logic [7:0] e[3] = '{8'h01, 8'h80, 8'hFF};
        wait_idle(200, ok);
        turbo = mode;
        base = rx_q.size();
        for (int k = 0; k < 3; k++) send(e[k]);
        n = 0;
        while (tx_busy !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        drops = 0;
        n = 0;
        while (rx_q.size() < base + 3 && n < 600) begin
            @(negedge clk);
            if (tx_busy !== 1'b1 && rx_q.size() < base + 3) drops++;
            n++;
        end
        total++; if (rx_q.size() < base + 3) begin bad++; $display("FAIL burst_count got=%0d want=3", rx_q.size() - base); end
        for (int k = 0; k < 3; k++) begin
            total++;
            if (rx_q[base+k] !== {1'b0, e[k]}) begin bad++; $display("FAIL burst_byte%0d got=%h want=%h", k, rx_q[base+k], e[k]); end
        end
        total++; if (drops != 0) begin bad++; $display("FAIL burst_busy_drop turbo=%0d got=%0d want=0", mode, drops); end
        for (int k = 1; k < 3; k++) begin
            total++;
            if (rx_t[base+k] - rx_t[base+k-1] != (mode ? 10 : 11))
            begin bad++; $display("FAIL burst_spacing turbo=%0d got=%0d want=%0d", mode, rx_t[base+k] - rx_t[base+k-1], mode ? 10 : 11); end
        end
        wait_frames(base + 4, 60, ok);
        total++; if (rx_q.size() != base + 3) begin bad++; $display("FAIL burst_repeat got=%0d want=3", rx_q.size() - base); end
    endtask

    task automatic test_fill();
        bit ok, acc;
        int base, i, n;
        logic [7:0] first;
        logic [7:0] d[DEPTH+2];
        wait_idle(200, ok);
        base = rx_q.size();
        first = 8'($urandom);
        for (int k = 0; k < DEPTH + 2; k++) d[k] = 8'($urandom);
        send(first);
        n = 0;
        while (tx_busy !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        stall = 1'b1;
        i = 0;
        for (int c = 0; c < DEPTH + 6; c++) begin
            wr_valid = 1'b1; wr_data = d[i]; acc = wr_ready;
            @(negedge clk);
            if (acc) i++;
        end
        total++; if (i != DEPTH) begin bad++; $display("FAIL fill_accepts got=%0d want=%0d", i, DEPTH); end
        total++; if (level !== DEPTH) begin bad++; $display("FAIL fill_level got=%0d want=%0d", level, DEPTH); end
        total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL fill_wr_ready got=%b want=0", wr_ready); end
        stall = 1'b0;
        n = 0;
        while (i < DEPTH + 2 && n < 500) begin
            wr_valid = 1'b1; wr_data = d[i]; acc = wr_ready;
            @(negedge clk);
            if (acc) i++;
            n++;
        end
        wr_valid = 1'b0;
        total++; if (i != DEPTH + 2) begin bad++; $display("FAIL fill_extra got=%0d want=%0d", i, DEPTH + 2); end
        wait_frames(base + DEPTH + 3, 3000, ok);
        total++; if (rx_q[base] !== {1'b0, first}) begin bad++; $display("FAIL fill_first got=%h want=%h", rx_q[base], first); end
        for (int k = 0; k < DEPTH + 2; k++) begin
            total++;
            if (rx_q[base+1+k] !== {1'b0, d[k]}) begin bad++; $display("FAIL fill_byte%0d got=%h want=%h", k, rx_q[base+1+k], d[k]); end
        end
    endtask

    task automatic test_late();
        bit ok;
        int base, n;
        logic [7:0] b;
        wait_idle(200, ok);
        base = rx_q.size();
        b = 8'($urandom);
        send(b);
        n = 0;
        while (tx_done !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        total++; if (tx_done !== 1'b1) begin bad++; $display("FAIL late_done_seen got=%b want=1", tx_done); end
        wr_valid = 1'b1; wr_data = 8'h3C;
        #1;
        total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL late_start got=%b want=0", tx_start); end
        @(posedge clk);
        #1 wr_valid = 1'b0;
        wait_frames(base + 2, 400, ok);
        wait_idle(200, ok);
        total++; if (rx_q[base] !== {1'b0, b}) begin bad++; $display("FAIL late_first got=%h want=%h", rx_q[base], b); end
        total++; if (rx_q[base+1] !== 9'h03C) begin bad++; $display("FAIL late_byte got=%h want=03c", rx_q[base+1]); end
        total++; if (rx_q.size() != base + 2) begin bad++; $display("FAIL late_count got=%0d want=2", rx_q.size() - base); end
    endtask

    task automatic test_push_pop();
        bit ok;
        int base, n;
        logic [7:0] a, b, c;
        wait_idle(200, ok);
        base = rx_q.size();
        a = 8'($urandom); b = 8'($urandom); c = ~b;
        send(a);
        n = 0;
        while (tx_busy !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        send(b);
        n = 0;
        @(negedge clk);
        while (tx_done !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        total++; if (level !== 1 || tx_start !== 1'b1) begin bad++; $display("FAIL pp_before got=%0d/%b want=1/1", level, tx_start); end
        total++; if (tx_data !== b) begin bad++; $display("FAIL pp_head_before got=%h want=%h", tx_data, b); end
        wr_valid = 1'b1; wr_data = c;
        @(posedge clk);
        #1 wr_valid = 1'b0;
        @(negedge clk);
        total++; if (level !== 1) begin bad++; $display("FAIL pp_level got=%0d want=1", level); end
        total++; if (tx_data !== c) begin bad++; $display("FAIL pp_head_after got=%h want=%h", tx_data, c); end
        wait_frames(base + 3, 600, ok);
        total++; if (rx_q[base] !== {1'b0, a}) begin bad++; $display("FAIL pp_a got=%h want=%h", rx_q[base], a); end
        total++; if (rx_q[base+1] !== {1'b0, b}) begin bad++; $display("FAIL pp_b got=%h want=%h", rx_q[base+1], b); end
        total++; if (rx_q[base+2] !== {1'b0, c}) begin bad++; $display("FAIL pp_c got=%h want=%h", rx_q[base+2], c); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int base, n;
        logic [7:0] b[4];
        wait_idle(200, ok);
        turbo = 1'b0;
        base = rx_q.size();
        for (int k = 0; k < 4; k++) begin b[k] = 8'($urandom); send(b[k]); end
        n = 0;
        while (!(ts == T_DATA && bidx == 3'd4) && n < 100) begin @(negedge clk); n++; end
        rst_n = 1'b0;
        #1;
        total++; if (level !== 0) begin bad++; $display("FAIL rmid_level got=%0d want=0", level); end
        total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL rmid_start got=%b want=0", tx_start); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++; if (idle !== 1'b0) begin bad++; $display("FAIL rmid_drain got=%b want=0", idle); end
        send(8'h55);
        wait_frames(base + 2, 600, ok);
        wait_idle(200, ok);
        total++; if (rx_q[base] !== {1'b0, b[0]}) begin bad++; $display("FAIL rmid_inflight got=%h want=%h", rx_q[base], b[0]); end
        total++; if (rx_q[base+1] !== 9'h055) begin bad++; $display("FAIL rmid_new got=%h want=055", rx_q[base+1]); end
        total++; if (rx_q.size() != base + 2) begin bad++; $display("FAIL rmid_count got=%0d want=2", rx_q.size() - base); end
    endtask

    task automatic test_random();
        bit ok;
        int base, cnt;
        logic [7:0] e[$];
        for (int r = 0; r < 4; r++) begin
            wait_idle(300, ok);
            turbo = 1'($urandom_range(0, 1));
            base = rx_q.size();
            cnt = $urandom_range(1, 8);
            e.delete();
            for (int k = 0; k < cnt; k++) begin
                e.push_back(8'($urandom));
                send(e[k]);
                repeat ($urandom_range(0, 12)) @(negedge clk);
            end
            wait_frames(base + cnt, 2000, ok);
            wait_idle(300, ok);
            total++; if (rx_q.size() != base + cnt) begin bad++; $display("FAIL rand%0d_count got=%0d want=%0d", r, rx_q.size() - base, cnt); end
            for (int k = 0; k < cnt; k++) begin
                total++;
                if (rx_q[base+k] !== {1'b0, e[k]}) begin bad++; $display("FAIL rand%0d_byte%0d got=%h want=%h", r, k, rx_q[base+k], e[k]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst(1'b1);
        test_burst(1'b0);
        test_fill();
        test_late();
        test_push_pop();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
